// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals shared by the arbiter and its users.
// Handshake: a requester raises req with stable addr/we/wdata and holds it until a one-cycle gnt; completion is a one-cycle done/rvalid.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_done, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    // Requester / memory side.
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_done, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and data access.
// Data wins by default; fetch wins a contended decision after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    mem_port_arbiter_if.slave                  bus,
    output logic [1:0]                         dbg_state,
    output logic [$clog2(STARVE_MAX+1)-1:0]    dbg_starve_cnt
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int SW    = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                owner_dm;
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [CNT_W-1:0]    wait_cnt;
    logic [SW-1:0]       starve_cnt;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;
    logic                if_rvalid_q;
    logic                dm_done_q;

    logic                any_req;
    logic                fetch_wins;
    logic                decide;
    logic                wait_expire;
    logic                issue;

    assign any_req     = bus.if_req | bus.dm_req;
    assign fetch_wins  = bus.if_req & (~bus.dm_req | (starve_cnt == SW'(STARVE_MAX)));
    assign decide      = (state == S_IDLE) & any_req;
    assign wait_expire = (state == S_WAIT) & (wait_cnt == CNT_W'(1));
    assign issue       = (state == S_ISSUE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (any_req) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (wait_cnt == CNT_W'(1)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request capture and arbitration bookkeeping happen only at the IDLE decision edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            owner_dm   <= 1'b0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            if (decide) begin
                owner_dm  <= ~fetch_wins;
                cap_we    <= ~fetch_wins & bus.dm_we;
                cap_addr  <= fetch_wins ? bus.if_addr : bus.dm_addr;
                cap_wdata <= fetch_wins ? '0 : bus.dm_wdata;
                if (fetch_wins) begin
                    starve_cnt <= '0;
                end else if (bus.if_req && (starve_cnt != SW'(STARVE_MAX))) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end
            if (issue) begin
                wait_cnt <= CNT_W'(MEM_LAT);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
        end
    end

    // Read data is sampled on the expiry edge; the completion pulse lands in the first IDLE cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_rvalid_q <= 1'b0;
            dm_done_q   <= 1'b0;
        end else begin
            if_rvalid_q <= wait_expire & ~owner_dm;
            dm_done_q   <= wait_expire & owner_dm;
            if (wait_expire && !cap_we) begin
                if (owner_dm) begin
                    dm_rdata_q <= bus.mem_rdata;
                end else begin
                    if_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt    = issue & ~owner_dm;
    assign bus.dm_gnt    = issue & owner_dm;
    assign bus.mem_en    = issue;
    assign bus.mem_we    = issue & cap_we;
    assign bus.mem_addr  = issue ? cap_addr  : '0;
    assign bus.mem_wdata = issue ? cap_wdata : '0;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = (state != S_IDLE);

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency synchronous memory between the instruction-fetch requester (PC/IM side) and the data requester (DM side) of the multicycle core. It arbitrates with data-side priority plus an anti-starvation override for fetch. It sequences each access through a grant/issue/wait/response flow and returns read data to the owning requester. The core's control FSM stalls on these handshakes instead of assuming single-cycle IM/DM.

Parameters:
ADDR_W, 10, word address width (memory depth 2^ADDR_W words)
DATA_W, 32, data width
MEM_LAT, 2, memory read latency in cycles from the mem_en cycle; legal range is 1 or more
STARVE_MAX, 4, consecutive fetch losses after which fetch wins the next contended decision

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-high
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetch data; held until next if_rvalid
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1=write, 0=read
dm_addr  in  ADDR_W  data word address
dm_wdata  in  DATA_W  write data
dm_gnt  out  1  one-cycle pulse: data request accepted
dm_done  out  1  one-cycle pulse: access complete (read or write)
dm_rdata  out  DATA_W  read data; held until next read dm_done, unchanged by writes
mem_en  out  1  one-cycle memory strobe
mem_we  out  1  memory write enable, valid with mem_en
mem_addr  out  ADDR_W  memory address, valid with mem_en
mem_wdata  out  DATA_W  memory write data, valid with mem_en
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en cycle
busy  out  1  high while a transfer is outstanding (state != IDLE)

Behaviour:
- Reset (asynchronous, rst_n=1): state IDLE. All outputs 0, including rdata registers. Starvation counter 0. Any in-flight transfer is discarded and no done/rvalid is produced for it.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: at a clock edge with any request high, make the decision, register the owner, capture addr/we/wdata, and go to ISSUE.
  - ISSUE: lasts one cycle. The granted gnt=1 and mem_en=1 with the captured mem_we/addr/wdata. Then go to WAIT and load the wait counter with MEM_LAT.
  - WAIT: the counter decrements each cycle. When it expires, sample mem_rdata into the owner's rdata (data reads and fetches only), pulse the owner's done/rvalid in the following cycle, and return to IDLE at that same edge.
- Timing (cycle 0 = grant cycle): mem_en in cycle 0. done/rvalid in cycle MEM_LAT+1. Earliest next grant is cycle MEM_LAT+2, provided the request is high at the edge that ends the done cycle. Throughput is 1 transfer per MEM_LAT+2 cycles.
- Arbitration: data-side requests win by default. If both request and starve_cnt==STARVE_MAX, fetch wins.
  - starve_cnt increments (saturating at STARVE_MAX) when data wins while if_req=1.
  - starve_cnt clears to 0 on any fetch grant.
  - Lone requests are granted immediately.
- Requests and inputs arriving while busy=1 are ignored until IDLE. Requesters must hold req and address stable until gnt. A req still high after done counts as a new request.
- Writes take the same full latency as reads. dm_done pulses for writes and dm_rdata is unchanged.
- gnt, mem_en, done and rvalid are never asserted for both requesters in the same cycle. mem_en is high for exactly one cycle per transfer.
- Address and data widths pass through unmodified, with no wrap or translation.

Test Plan:
- Reset mid-WAIT: assert rst_n=1 during cycle 2 of a fetch (MEM_LAT=2) -> all outputs 0 immediately, no if_rvalid, busy=0. After release, a new fetch of addr 0x004 completes normally.
- Lone fetch, MEM_LAT=2, mem returns 0x8C010004 for addr 0x001 -> if_gnt and mem_en (we=0, addr 0x001) in cycle 0; if_rvalid in cycle 3 with if_rdata=0x8C010004; busy high in cycles 0-2.
- Data write addr 0x010 wdata 0xDEADBEEF -> mem_en, mem_we=1, mem_wdata=0xDEADBEEF in cycle 0; dm_done in cycle 3; dm_rdata unchanged from its prior value.
- Simultaneous if_req and dm_req, starve_cnt=0 -> dm granted first. Both held continuously with STARVE_MAX=4 -> grant order D,D,D,D,I,D,... and starve_cnt returns to 0 after the I grant.
- Back-to-back fetches with if_req held, MEM_LAT=1 -> grants in cycles 0, 3, 6; exactly one mem_en per transfer.
- MEM_LAT=5 read, dm_addr changed after dm_gnt -> mem_addr is the captured original value; dm_done in cycle 6 with the original word.
